spi_cfg_bank: RTL and testbench



---
 rtl/spi_cfg_pkg.sv | 20 ++
 rtl/spi_cfg_bank_if.sv | 13 +
 rtl/spi_pin_sync.sv | 35 +++
 rtl/spi_cfg_bank.sv | 236 +++++++++++++++++++++++
 tb/tb_spi_cfg_bank.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_cfg_pkg.sv
// rtl/spi_cfg_pkg.sv - shared types and constants for the SPI configuration bank
package spi_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA,
        ERR
    } cfg_state_t;

    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_READ  = 1'b1;

    // Command header length: one R/W bit followed by the address bits.
    function automatic int frame_cmd_len(input int addr_w);
        return 1 + addr_w;
    endfunction

endpackage

// File: rtl/spi_cfg_bank_if.sv
// rtl/spi_cfg_bank_if.sv - SPI programming pin bundle
// SCLK/CS/SDI: master to slave, CS active low.
// SDO/SDO_OE: slave to master readback data and its output enable.
interface spi_cfg_bank_if;
    logic SCLK;
    logic CS;
    logic SDI;
    logic SDO;
    logic SDO_OE;

    modport master (output SCLK, output CS, output SDI, input SDO, input SDO_OE);
    modport slave  (input SCLK, input CS, input SDI, output SDO, output SDO_OE);
endinterface

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - 2-FF pin synchroniser with registered edge detect
// clk, reset : system clock, synchronous active-high reset
// pin        : asynchronous input pin
// level      : synchronised level
// rise, fall : single-cycle edge pulses, aligned with level
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta;
    logic sync_q;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= RST_VAL;
            sync_q <= RST_VAL;
            prev   <= RST_VAL;
        end else begin
            meta   <= pin;
            sync_q <= meta;
            prev   <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev;
    assign fall  = ~sync_q & prev;
endmodule

// File: rtl/spi_cfg_bank.sv
// rtl/spi_cfg_bank.sv - oversampled SPI mode-0 slave holding a bank of configuration registers
// clk, reset : system clock, synchronous active-high reset
// spi        : SCLK/CS/SDI in, SDO/SDO_OE out (readback)
// cfg_data   : live register image, register i at [i*REG_W +: REG_W]
// cfg_update : one-cycle pulse when a write frame commits
// frame_err  : one-cycle pulse when a frame is discarded
module spi_cfg_bank
    import spi_cfg_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int REG_W    = 16,
    parameter logic [NUM_REGS*REG_W-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    spi_cfg_bank_if.slave             spi,
    output logic [NUM_REGS*REG_W-1:0] cfg_data,
    output logic                      cfg_update,
    output logic                      frame_err
);
    localparam int ADDR_W  = $clog2(NUM_REGS);
    localparam int CMD_LEN = frame_cmd_len(ADDR_W);
    localparam int PTR_W   = ADDR_W + 1;
    localparam int CNT_MAX = (REG_W > CMD_LEN) ? REG_W : CMD_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [PTR_W-1:0] NREGS_P   = PTR_W'(NUM_REGS);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_LEN - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(REG_W - 1);

    logic       sclk_rise, sclk_fall, sclk_lvl_unused;
    logic       cs_lvl, cs_rise, cs_fall;
    logic       sdi_lvl;
    logic [1:0] sdi_edges_unused;

    spi_pin_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .pin(spi.SCLK),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_pin_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .pin(spi.CS),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_pin_sync #(.RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .reset(reset), .pin(spi.SDI),
        .level(sdi_lvl), .rise(sdi_edges_unused[0]), .fall(sdi_edges_unused[1])
    );

    cfg_state_t state, state_n;

    logic [REG_W-1:0]   live  [NUM_REGS];
    logic [REG_W-1:0]   stage [NUM_REGS];
    logic [1:0]         warm;
    logic               armed;
    logic [CNT_W-1:0]   cnt;
    logic [PTR_W-1:0]   ptr;
    logic               got_word;
    logic               rd_over;
    logic               sdo_q;
    logic [CMD_LEN-2:0] cmd_sr;
    logic [REG_W-2:0]   wsr;
    logic [REG_W-1:0]   rsr;

    logic [CMD_LEN-1:0] cmd_bits;
    logic [PTR_W-1:0]   cmd_addr;
    logic [REG_W-1:0]   wr_word;
    logic [REG_W-1:0]   rd_word;
    logic               do_start, do_commit, do_err;
    logic               cmd_bit, wr_bit, rd_fall;

    assign cmd_bits = {cmd_sr, sdi_lvl};
    assign cmd_addr = {1'b0, cmd_bits[ADDR_W-1:0]};
    assign wr_word  = {wsr, sdi_lvl};
    assign rd_word  = live[ptr[ADDR_W-1:0]];

    // CS rise wins over any SCLK edge seen in the same cycle.
    assign cmd_bit = (state == CMD) && !cs_rise && sclk_rise;
    assign wr_bit  = (state == WDATA) && (state_n == WDATA) && sclk_rise;
    assign rd_fall = (state == RDATA) && !cs_rise && sclk_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        do_start  = 1'b0;
        do_commit = 1'b0;
        do_err    = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall && armed) begin
                    state_n  = CMD;
                    do_start = 1'b1;
                end
            end
            CMD: begin
                if (cs_rise) begin
                    state_n = IDLE;
                    do_err  = (cnt != '0);
                end else if (sclk_rise && (cnt == CMD_LAST)) begin
                    if (cmd_addr >= NREGS_P) begin
                        state_n = ERR;
                    end else if (cmd_bits[CMD_LEN-1] == CMD_READ) begin
                        state_n = RDATA;
                    end else if (cmd_bits[CMD_LEN-1] == CMD_WRITE) begin
                        state_n = WDATA;
                    end else begin
                        state_n = ERR;
                    end
                end
            end
            WDATA: begin
                if (cs_rise) begin
                    state_n = IDLE;
                    if ((cnt == '0) && got_word) begin
                        do_commit = 1'b1;
                    end else begin
                        do_err = 1'b1;
                    end
                end else if (sclk_rise && (cnt == '0) && (ptr >= NREGS_P)) begin
                    state_n = ERR;
                end
            end
            RDATA: begin
                if (cs_rise) begin
                    state_n = IDLE;
                end else if (sclk_rise && rd_over) begin
                    state_n = ERR;
                end
            end
            ERR: begin
                if (cs_rise) begin
                    state_n = IDLE;
                    do_err  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Stage is a scratch copy; its contents only matter between CS fall and commit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (do_start) begin
                stage <= live;
            end else if (wr_bit && (cnt == WORD_LAST)) begin
                stage[ptr[ADDR_W-1:0]] <= wr_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                live[i] <= RESET_VAL[i*REG_W +: REG_W];
            end
            cfg_update <= 1'b0;
            frame_err  <= 1'b0;
            warm       <= '0;
            armed      <= 1'b0;
            cnt        <= '0;
            ptr        <= '0;
            got_word   <= 1'b0;
            rd_over    <= 1'b0;
            sdo_q      <= 1'b0;
            cmd_sr     <= '0;
            wsr        <= '0;
            rsr        <= '0;
        end else begin
            cfg_update <= do_commit;
            frame_err  <= do_err;
            // CS level is only trusted once the synchroniser holds real pin samples;
            // a frame may start only after CS has been seen high since reset.
            warm <= {warm[0], 1'b1};
            if (warm[1] && cs_lvl) begin
                armed <= 1'b1;
            end
            if (do_commit) begin
                live <= stage;
            end
            if (do_start) begin
                cnt      <= '0;
                cmd_sr   <= '0;
                got_word <= 1'b0;
                rd_over  <= 1'b0;
                sdo_q    <= 1'b0;
            end else if (cmd_bit) begin
                cmd_sr <= cmd_bits[CMD_LEN-2:0];
                if (cnt == CMD_LAST) begin
                    cnt <= '0;
                    ptr <= cmd_addr;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (wr_bit) begin
                wsr <= wr_word[REG_W-2:0];
                if (cnt == WORD_LAST) begin
                    cnt      <= '0;
                    ptr      <= ptr + PTR_W'(1);
                    got_word <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (rd_fall) begin
                // The trailing SCLK fall after the last wanted bit also opens a word;
                // reading past the bank is only an error once a bit is actually clocked.
                if (cnt == '0) begin
                    if (ptr >= NREGS_P) begin
                        rd_over <= 1'b1;
                        sdo_q   <= 1'b0;
                    end else begin
                        sdo_q <= rd_word[REG_W-1];
                        rsr   <= {rd_word[REG_W-2:0], 1'b0};
                        ptr   <= ptr + PTR_W'(1);
                        cnt   <= (cnt == WORD_LAST) ? '0 : cnt + CNT_W'(1);
                    end
                end else begin
                    sdo_q <= rsr[REG_W-1];
                    rsr   <= {rsr[REG_W-2:0], 1'b0};
                    cnt   <= (cnt == WORD_LAST) ? '0 : cnt + CNT_W'(1);
                end
            end
        end
    end

    assign spi.SDO    = (state == RDATA) ? sdo_q : 1'b0;
    assign spi.SDO_OE = (state == RDATA);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
        assign cfg_data[g*REG_W +: REG_W] = live[g];
    end
endmodule

// File: tb/tb_spi_cfg_bank.sv
// tb/tb_spi_cfg_bank.sv - directed scoreboard bench for spi_cfg_bank
module tb_spi_cfg_bank;
    localparam int W = 128;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] cfg_data;
    logic         cfg_update;
    logic         frame_err;

    spi_cfg_bank_if spi ();

    spi_cfg_bank #(.NUM_REGS(8), .REG_W(16), .RESET_VAL('0)) dut (
        .clk(clk), .reset(reset), .spi(spi),
        .cfg_data(cfg_data), .cfg_update(cfg_update), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int           vectors     = 0;
    int           miscompares = 0;
    int           upd_cnt     = 0;
    int           err_cnt     = 0;
    logic [W-1:0] model       = '0;
    logic [W-1:0] exp_img;
    logic [W-1:0] img_q [$];
    logic         exp_bit_q [$];
    bit           rd_check    = 1'b0;
    int           rd_idx      = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every committed image must match the next expected one.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (cfg_update) begin
                upd_cnt++;
                exp_img = (img_q.size() > 0) ? img_q.pop_front() : {W{1'bx}};
                check("update_image", cfg_data, exp_img);
            end
            if (frame_err) err_cnt++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low(input int half);
        spi.CS = 1'b0;
        wait_clk(half);
    endtask

    task automatic cs_high(input int half);
        wait_clk(half);
        spi.CS = 1'b1;
    endtask

    task automatic send_bit(input logic b, input int half);
        logic e;
        spi.SDI = b;
        wait_clk(half);
        if (rd_check) begin
            check("sdo_oe", W'(spi.SDO_OE), W'(rd_idx >= 4));
            if (rd_idx >= 4) begin
                e = (exp_bit_q.size() > 0) ? exp_bit_q.pop_front() : 1'bx;
                check("sdo_bit", W'(spi.SDO), W'(e));
            end
            rd_idx++;
        end
        spi.SCLK = 1'b1;
        wait_clk(half);
        spi.SCLK = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] v, input int n, input int half);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], half);
    endtask

    task automatic frame(input logic rw, input logic [2:0] addr, input logic [63:0] data,
                         input int nbits, input int half);
        cs_low(half);
        send_bit(rw, half);
        send_bits({61'd0, addr}, 3, half);
        send_bits(data, nbits, half);
        cs_high(half);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int u0, e0, lat;
        logic [15:0] rd_val;

        spi.CS = 1'b1; spi.SCLK = 1'b0; spi.SDI = 1'b0; reset = 1'b1;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(4);
        check("reset_cfg_data", cfg_data, '0);
        check("reset_update", W'(cfg_update), '0);
        check("reset_err", W'(frame_err), '0);
        check("reset_oe", W'(spi.SDO_OE), '0);
        check("reset_sdo", W'(spi.SDO), '0);

        // single write to reg 2
        u0 = upd_cnt; e0 = err_cnt;
        model[47:32] = 16'hA5C3;
        img_q.push_back(model);
        frame(1'b0, 3'd2, 64'hA5C3, 16, 6);
        wait_clk(10);
        check("w2_data", cfg_data, model);
        check("w2_upd", W'(upd_cnt - u0), W'(1));
        check("w2_err", W'(err_cnt - e0), W'(0));

        // readback of reg 2
        u0 = upd_cnt; e0 = err_cnt;
        rd_val = 16'hA5C3;
        for (int i = 15; i >= 0; i--) exp_bit_q.push_back(rd_val[i]);
        rd_idx = 0; rd_check = 1'b1;
        frame(1'b1, 3'd2, 64'h0, 16, 6);
        rd_check = 1'b0;
        wait_clk(10);
        check("rd_bits_left", W'(exp_bit_q.size()), W'(0));
        check("rd_upd", W'(upd_cnt - u0), W'(0));
        check("rd_err", W'(err_cnt - e0), W'(0));
        check("rd_oe_after", W'(spi.SDO_OE), '0);
        check("rd_sdo_after", W'(spi.SDO), '0);
        check("rd_data", cfg_data, model);

        // two-word burst at the top of the bank
        u0 = upd_cnt; e0 = err_cnt;
        model[111:96] = 16'h1111;
        model[127:112] = 16'h2222;
        img_q.push_back(model);
        frame(1'b0, 3'd6, 64'h1111_2222, 32, 6);
        wait_clk(10);
        check("burst_data", cfg_data, model);
        check("burst_upd", W'(upd_cnt - u0), W'(1));
        check("burst_err", W'(err_cnt - e0), W'(0));

        // three-word burst overruns the bank
        u0 = upd_cnt; e0 = err_cnt;
        frame(1'b0, 3'd6, 64'h3333_4444_5555, 48, 6);
        wait_clk(10);
        check("ovr_data", cfg_data, model);
        check("ovr_upd", W'(upd_cnt - u0), W'(0));
        check("ovr_err", W'(err_cnt - e0), W'(1));

        // write to reg 3 cut after 11 data bits
        u0 = upd_cnt; e0 = err_cnt;
        frame(1'b0, 3'd3, 64'h5AA, 11, 6);
        wait_clk(10);
        check("abort_data", cfg_data, model);
        check("abort_upd", W'(upd_cnt - u0), W'(0));
        check("abort_err", W'(err_cnt - e0), W'(1));

        u0 = upd_cnt; e0 = err_cnt;
        model[63:48] = 16'h00FF;
        img_q.push_back(model);
        frame(1'b0, 3'd3, 64'h00FF, 16, 6);
        wait_clk(10);
        check("w3_data", cfg_data, model);
        check("w3_upd", W'(upd_cnt - u0), W'(1));
        check("w3_err", W'(err_cnt - e0), W'(0));

        // reset mid-frame with CS held low across release
        cs_low(6);
        send_bits({1'b0, 3'd5, 8'hFF}, 12, 6);
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        model = '0;
        wait_clk(2);
        u0 = upd_cnt; e0 = err_cnt;
        check("mid_rst_data", cfg_data, model);
        check("mid_rst_upd", W'(cfg_update), '0);
        check("mid_rst_err", W'(frame_err), '0);
        check("mid_rst_oe", W'(spi.SDO_OE), '0);
        send_bits(64'h77, 8, 6);
        send_bits(64'hFFFF, 16, 6);
        cs_high(6);
        wait_clk(10);
        check("tail_data", cfg_data, model);
        check("tail_upd", W'(upd_cnt - u0), W'(0));
        check("tail_err", W'(err_cnt - e0), W'(0));

        u0 = upd_cnt; e0 = err_cnt;
        model[95:80] = 16'h5A5A;
        img_q.push_back(model);
        frame(1'b0, 3'd5, 64'h5A5A, 16, 6);
        wait_clk(10);
        check("w5_data", cfg_data, model);
        check("w5_upd", W'(upd_cnt - u0), W'(1));
        check("w5_err", W'(err_cnt - e0), W'(0));

        // minimum SCLK phases and commit latency from the CS pin rise
        u0 = upd_cnt; e0 = err_cnt;
        model[127:112] = 16'h8001;
        img_q.push_back(model);
        cs_low(4);
        send_bit(1'b0, 4);
        send_bits(64'd7, 3, 4);
        send_bits(64'h8001, 16, 4);
        wait_clk(4);
        spi.CS = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (cfg_update && lat == 0) lat = k;
        end
        check("fast_lat_ok", W'((lat == 3) || (lat == 4)), W'(1));
        wait_clk(4);
        check("fast_data", cfg_data, model);
        check("fast_upd", W'(upd_cnt - u0), W'(1));
        check("fast_err", W'(err_cnt - e0), W'(0));
        check("img_q_drained", W'(img_q.size()), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
